dm_responder: RTL

Multi-cycle data-memory responder: the memory side of the processor's load/store interface. Accepts one request at a time on a valid/ready request channel. Performs the read or write after a fixed number of wait states. Returns the result on a valid/ready response channel. Sits between the SISC core's memory-access path and a word-addressed 32-bit storage array held inside this block.

---
 rtl/dm_responder.sv | 91 +++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle word-addressed data memory with valid/ready request and response channels.
// Optional DM_RANGE_CHECK_EN flags out-of-range addresses instead of wrapping them.
module dm_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
`ifdef DM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} state_t;
    state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [2**DEPTH_LOG2];
    logic        accept, access, acc_we, oor, wr_en;
    logic [15:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    // With WAIT=0 the access happens on the acceptance edge, so it must use the live request.
    assign accept    = (state == IDLE) && req_valid;
    assign access    = rst_f && ((accept && WAIT == 0) || (state == WAIT_ST && cnt == 4'd1));
    assign acc_we    = (state == IDLE) ? req_we : lat_we;
    assign acc_addr  = (state == IDLE) ? req_addr : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign idx       = acc_addr[DEPTH_LOG2-1:0];
    assign oor       = RANGE_EN && ((acc_addr >> DEPTH_LOG2) != 16'd0);
    assign wr_en     = access && acc_we && !oor;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req_valid) begin
                cnt_nxt   = 4'(WAIT);
                state_nxt = (WAIT == 0) ? RESP : WAIT_ST;
            end
            WAIT_ST: begin
                cnt_nxt   = cnt - 4'd1;
                state_nxt = (cnt == 4'd1) ? RESP : WAIT_ST;
            end
            RESP: state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 16'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (access) begin
                rsp_rdata <= oor ? 32'd0 : (acc_we ? acc_wdata : mem[idx]);
                rsp_err   <= oor;
            end
        end
    end
    // Storage deliberately has no reset so contents survive rst_f.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= acc_wdata;
    end
endmodule
